// File: rtl/hopfield_seq_core.sv
// Hopfield associative memory: Hebbian learning into a saturating weight matrix
// and sequential recall, one neuron at a time, until stable or out of sweeps.
module hopfield_seq_core #(
   parameter int N          = 8,
   parameter int W          = 8,
   parameter int MAX_SWEEPS = 16,
   localparam int IW = $clog2(N),
   localparam int SW = $clog2(MAX_SWEEPS + 1),
   localparam int AW = W + $clog2(N) + 1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic                mode,
   input  logic                clear_weights,
   input  logic [N-1:0]        pattern_in,
   input  logic [IW-1:0]       rd_row,
   input  logic [IW-1:0]       rd_col,
   output logic signed [W-1:0] rd_weight,
   output logic                busy,
   output logic                done,
   output logic                converged,
   output logic [SW-1:0]       sweeps,
   output logic [N-1:0]        state_out
);

   typedef enum logic [2:0] {IDLE, LEARN, LOAD, ACC, UPD, DONE} state_e;

   localparam logic signed [W-1:0] WMAX = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0] WMIN = -WMAX;

   state_e               state_q;
   logic signed [W-1:0]  weight_q [N][N];
   logic [N-1:0]         pattern_q;
   logic [N-1:0]         neuronState_q;
   logic [N-1:0]         updState_d;
   logic [IW-1:0]        row_q;
   logic [IW-1:0]        col_q;
   logic signed [AW-1:0] accum_q;
   logic signed [AW-1:0] accum_d;
   logic signed [AW-1:0] term_d;
   logic signed [AW-1:0] weightExt_d;
   logic                 change_q;
   logic                 changeNow_d;
   logic                 converged_q;
   logic                 busy_q;
   logic                 done_q;
   logic [SW-1:0]        sweeps_q;
   logic [SW-1:0]        sweepsNext_d;

   // Symmetric clamp keeps the most negative code out so negation never overflows.
   function automatic logic signed [W-1:0] satStep(input logic signed [W-1:0] w,
                                                   input logic up);
      if (up)
         return (w == WMAX) ? w : w + W'(1);
      return (w == WMIN) ? w : w - W'(1);
   endfunction

   // Row r is trained in learn cycle r; the diagonal is never written.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
               weight_q[i][j] <= '0;
      end else if (state_q == IDLE && clear_weights) begin
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
               weight_q[i][j] <= '0;
      end else if (state_q == LEARN) begin
         for (int j = 0; j < N; j++)
            if (IW'(j) != row_q)
               weight_q[row_q][j] <= satStep(weight_q[row_q][j],
                                             pattern_q[row_q] == pattern_q[j]);
      end
   end

   always_comb begin
      weightExt_d = AW'(weight_q[row_q][col_q]);
      term_d      = '0;
      if (col_q != row_q)
         term_d = neuronState_q[col_q] ? weightExt_d : -weightExt_d;
      accum_d = term_d;
      if (col_q != '0)
         accum_d = accum_q + term_d;

      // A zero field leaves the neuron where it was.
      updState_d = neuronState_q;
      if (accum_q[AW-1])
         updState_d[row_q] = 1'b0;
      else if (accum_q != '0)
         updState_d[row_q] = 1'b1;
      changeNow_d  = change_q | (updState_d != neuronState_q);
      sweepsNext_d = sweeps_q + SW'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         pattern_q     <= '0;
         neuronState_q <= '0;
         row_q         <= '0;
         col_q         <= '0;
         accum_q       <= '0;
         change_q      <= 1'b0;
         converged_q   <= 1'b0;
         sweeps_q      <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start && !clear_weights) begin
                  pattern_q <= pattern_in;
                  row_q     <= '0;
                  col_q     <= '0;
                  busy_q    <= 1'b1;
                  state_q   <= mode ? LOAD : LEARN;
               end
            end
            LEARN: begin
               if (row_q == IW'(N - 1)) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end else begin
                  row_q <= row_q + IW'(1);
               end
            end
            LOAD: begin
               neuronState_q <= pattern_q;
               sweeps_q      <= '0;
               converged_q   <= 1'b0;
               change_q      <= 1'b0;
               row_q         <= '0;
               col_q         <= '0;
               state_q       <= ACC;
            end
            ACC: begin
               accum_q <= accum_d;
               if (col_q == IW'(N - 1)) begin
                  col_q   <= '0;
                  state_q <= UPD;
               end else begin
                  col_q <= col_q + IW'(1);
               end
            end
            UPD: begin
               neuronState_q <= updState_d;
               if (row_q == IW'(N - 1)) begin
                  sweeps_q <= sweepsNext_d;
                  row_q    <= '0;
                  change_q <= 1'b0;
                  if (!changeNow_d) begin
                     converged_q <= 1'b1;
                     done_q      <= 1'b1;
                     state_q     <= DONE;
                  end else if (sweepsNext_d == SW'(MAX_SWEEPS)) begin
                     converged_q <= 1'b0;
                     done_q      <= 1'b1;
                     state_q     <= DONE;
                  end else begin
                     state_q <= ACC;
                  end
               end else begin
                  row_q    <= row_q + IW'(1);
                  change_q <= changeNow_d;
                  state_q  <= ACC;
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rd_weight = weight_q[rd_row][rd_col];
   assign busy      = busy_q;
   assign done      = done_q;
   assign converged = converged_q;
   assign sweeps    = sweeps_q;
   assign state_out = neuronState_q;

endmodule

// File: tb/tb_hopfield_seq_core.sv
// Bench for hopfield_seq_core: two N=4 cores (deep and single-sweep recall
// limits) driven in lockstep and compared against an arithmetic Hopfield model.
module tb_hopfield_seq_core;

   localparam int N    = 4;
   localparam int W    = 8;
   localparam int WLIM = 127;
   localparam int MAXA = 16;
   localparam int MAXB = 1;

   logic                clk = 1'b0;
   logic                reset_n;
   logic                start;
   logic                mode;
   logic                clearWeights;
   logic [N-1:0]        patternIn;
   logic [1:0]          rdRow;
   logic [1:0]          rdCol;
   logic signed [W-1:0] rdWeightA;
   logic signed [W-1:0] rdWeightB;
   logic                busyA, busyB, doneA, doneB, convA, convB;
   logic [4:0]          sweepsA;
   logic [0:0]          sweepsB;
   logic [N-1:0]        stateA, stateB;

   int totalChecks = 0;
   int badChecks   = 0;
   int wm [N][N];

   hopfield_seq_core #(.N(N), .W(W), .MAX_SWEEPS(MAXA)) dutA (
      .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
      .clear_weights(clearWeights), .pattern_in(patternIn),
      .rd_row(rdRow), .rd_col(rdCol), .rd_weight(rdWeightA),
      .busy(busyA), .done(doneA), .converged(convA),
      .sweeps(sweepsA), .state_out(stateA)
   );

   hopfield_seq_core #(.N(N), .W(W), .MAX_SWEEPS(MAXB)) dutB (
      .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
      .clear_weights(clearWeights), .pattern_in(patternIn),
      .rd_row(rdRow), .rd_col(rdCol), .rd_weight(rdWeightB),
      .busy(busyB), .done(doneB), .converged(convB),
      .sweeps(sweepsB), .state_out(stateB)
   );

   always #5 clk = ~clk;

   // Every comparison funnels through here so the counts stay honest.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      totalChecks++;
      if (observed !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Hebbian rule on the model: agreeing bits pull a weight up, disagreeing down.
   task automatic modelLearn(input logic [N-1:0] p);
      for (int r = 0; r < N; r++)
         for (int j = 0; j < N; j++)
            if (j != r) begin
               wm[r][j] += (p[r] == p[j]) ? 1 : -1;
               if (wm[r][j] > WLIM)  wm[r][j] = WLIM;
               if (wm[r][j] < -WLIM) wm[r][j] = -WLIM;
            end
   endtask

   task automatic modelClear();
      for (int r = 0; r < N; r++)
         for (int j = 0; j < N; j++)
            wm[r][j] = 0;
   endtask

   // Asynchronous recall: each neuron sees the freshest values of the others.
   task automatic modelRecall(input logic [N-1:0] p, input int maxSw,
                              output logic [N-1:0] s, output int conv, output int sw);
      int  acc;
      bit  changed;
      s    = p;
      conv = 0;
      sw   = 0;
      for (int k = 0; k < maxSw; k++) begin
         changed = 0;
         for (int i = 0; i < N; i++) begin
            acc = 0;
            for (int j = 0; j < N; j++)
               if (j != i) acc += wm[i][j] * (s[j] ? 1 : -1);
            if (acc > 0 && !s[i]) begin s[i] = 1'b1; changed = 1; end
            else if (acc < 0 && s[i]) begin s[i] = 1'b0; changed = 1; end
         end
         sw++;
         if (!changed) begin
            conv = 1;
            break;
         end
      end
   endtask

   task automatic checkWeights(input string tag);
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            rdRow = 2'(r);
            rdCol = 2'(c);
            #1;
            checkOutput($sformatf("%s_wA%0d%0d", tag, r, c), int'(rdWeightA), wm[r][c]);
            checkOutput($sformatf("%s_wB%0d%0d", tag, r, c), int'(rdWeightB), wm[r][c]);
         end
   endtask

   // Runs one learn or recall on both cores, jiggling inputs that must be ignored while busy.
   task automatic applyStimulus(input logic m, input logic [N-1:0] p, input string tag);
      int           expDoneA, expDoneB, seenA, seenB, k;
      int           expConvA, expConvB, expSwA, expSwB;
      int           prevConvA, prevSwA;
      logic [N-1:0] expStA, expStB, prevA, prevB;
      prevA     = stateA;
      prevB     = stateB;
      prevConvA = convA;
      prevSwA   = sweepsA;
      expConvA  = 0; expConvB = 0; expSwA = 0; expSwB = 0;
      expStA    = '0; expStB = '0;
      if (m) begin
         modelRecall(p, MAXA, expStA, expConvA, expSwA);
         modelRecall(p, MAXB, expStB, expConvB, expSwB);
         expDoneA = 2 + expSwA * N * (N + 1);
         expDoneB = 2 + expSwB * N * (N + 1);
      end else begin
         expDoneA = N + 1;
         expDoneB = N + 1;
      end
      @(negedge clk);
      start = 1'b1; mode = m; patternIn = p; clearWeights = 1'b0;
      @(negedge clk);
      start = 1'b0;
      checkOutput({tag, "_busy"}, busyA, 1);
      seenA = 0; seenB = 0; k = 1;
      while (k <= 340) begin
         if (doneA && seenA == 0) seenA = k;
         if (doneB && seenB == 0) seenB = k;
         if (seenA != 0 && seenB != 0) break;
         patternIn = N'($urandom);
         mode      = 1'($urandom);
         if (!m) begin
            start        = 1'($urandom);
            clearWeights = 1'($urandom);
         end
         @(negedge clk);
         k++;
      end
      start = 1'b0; clearWeights = 1'b0; mode = 1'b0;
      checkOutput({tag, "_doneA"}, seenA, expDoneA);
      checkOutput({tag, "_doneB"}, seenB, expDoneB);
      if (m) begin
         checkOutput({tag, "_stateA"}, stateA, expStA);
         checkOutput({tag, "_convA"}, convA, expConvA);
         checkOutput({tag, "_sweepsA"}, sweepsA, expSwA);
         checkOutput({tag, "_stateB"}, stateB, expStB);
         checkOutput({tag, "_convB"}, convB, expConvB);
         checkOutput({tag, "_sweepsB"}, sweepsB, expSwB);
      end else begin
         start = 1'b1; mode = 1'b1;
         @(negedge clk);
         checkOutput({tag, "_ignoreStartInDone"}, busyA, 0);
         checkOutput({tag, "_donePulse"}, doneA, 0);
         start = 1'b0; mode = 1'b0;
         checkOutput({tag, "_stateKeptA"}, stateA, prevA);
         checkOutput({tag, "_stateKeptB"}, stateB, prevB);
         checkOutput({tag, "_convKept"}, convA, prevConvA);
         checkOutput({tag, "_sweepsKept"}, sweepsA, prevSwA);
         modelLearn(p);
      end
   endtask

   task automatic clearViaPort(input string tag);
      @(negedge clk);
      clearWeights = 1'b1; start = 1'b1; mode = 1'($urandom); patternIn = N'($urandom);
      @(negedge clk);
      clearWeights = 1'b0; start = 1'b0;
      checkOutput({tag, "_startBlocked"}, busyA, 0);
      modelClear();
      checkWeights(tag);
   endtask

   // Directed corner cases first, then random learn/recall rounds, then a mid-recall reset.
   initial begin
      int seenDone;
      reset_n = 1'b0; start = 1'b0; mode = 1'b0; clearWeights = 1'b0;
      patternIn = '0; rdRow = '0; rdCol = '0;
      modelClear();
      repeat (3) @(negedge clk);
      checkOutput("rst_busy", busyA, 0);
      checkOutput("rst_done", doneA, 0);
      checkOutput("rst_conv", convA, 0);
      checkOutput("rst_sweeps", sweepsA, 0);
      checkOutput("rst_state", stateA, 0);
      checkOutput("rst_busyB", busyB, 0);
      checkWeights("rst");
      reset_n = 1'b1;

      applyStimulus(1'b0, 4'b1010, "learn1010");
      checkWeights("after1010");
      rdRow = 2'd0; rdCol = 2'd1; #1;
      checkOutput("w01_is_minus1", int'(rdWeightA), -1);
      rdRow = 2'd1; rdCol = 2'd3; #1;
      checkOutput("w13_is_plus1", int'(rdWeightA), 1);
      applyStimulus(1'b1, 4'b1011, "recall1011");
      checkOutput("recall1011_final", stateA, 4'b1010);

      clearViaPort("clr1");
      applyStimulus(1'b1, 4'b0110, "zeroW");

      for (int i = 0; i < 200; i++)
         applyStimulus(1'b0, 4'b0000, "sat0000");
      checkWeights("sat");
      applyStimulus(1'b0, 4'b0101, "sat0101");
      checkWeights("sat0101");
      rdRow = 2'd0; rdCol = 2'd1; #1;
      checkOutput("sat_w01", int'(rdWeightA), 126);

      clearViaPort("clr2");
      for (int round = 0; round < 6; round++) begin
         int nLearn;
         nLearn = $urandom_range(1, 3);
         for (int i = 0; i < nLearn; i++)
            applyStimulus(1'b0, N'($urandom), $sformatf("rl%0d_%0d", round, i));
         checkWeights($sformatf("rw%0d", round));
         for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, N'($urandom), $sformatf("rr%0d_%0d", round, i));
      end

      @(negedge clk);
      start = 1'b1; mode = 1'b1; patternIn = N'($urandom);
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      reset_n = 1'b0;
      #1;
      checkOutput("midRst_busy", busyA, 0);
      checkOutput("midRst_busyB", busyB, 0);
      checkOutput("midRst_state", stateA, 0);
      checkOutput("midRst_conv", convA, 0);
      checkOutput("midRst_sweeps", sweepsA, 0);
      seenDone = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (doneA || doneB) seenDone = 1;
      end
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (doneA || doneB || busyA) seenDone = 1;
      end
      checkOutput("midRst_noDone", seenDone, 0);
      modelClear();
      checkWeights("midRst");
      applyStimulus(1'b0, N'($urandom), "postRstLearn");
      checkWeights("postRst");
      applyStimulus(1'b1, N'($urandom), "postRstRecall");

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
